mult32_seq: RTL and testbench

Iterative 32x32 shift-add multiplier for the datapath's MUL instruction, producing a 64-bit product as HI/LO words. It sits in the execute stage beside the ALU, downstream of the operand registers (32-bit registers) and the 32/64-bit two's-complement logic. It converts signed operands to magnitudes, multiplies over 32 cycles, and then applies the result sign. The control unit starts an operation and stalls on BUSY until DONE.

---
 rtl/mult32_seq_if.sv | 34 +++
 rtl/mult32_seq.sv | 92 +++++++++
 tb/tb_mult32_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mult32_seq_if.sv
// Operand/result bundle between the control unit and the iterative multiplier.
// master drives the request; slave returns the registered product and status.
interface mult32_seq_if;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output is_signed,
    output a,
    output b,
    input  hi,
    input  lo,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  is_signed,
    input  a,
    input  b,
    output hi,
    output lo,
    output busy,
    output done
  );
endinterface

// File: rtl/mult32_seq.sv
// Iterative 32x32 shift-add multiplier: signed operands become magnitudes, 32 add/shift
// iterations follow, then the sign is applied and HI/LO are written in one step.
module mult32_seq (
  input logic          clk,
  input logic          rst,
  mult32_seq_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      state_q;
  logic [31:0] mcand_q;
  logic [31:0] mult_q;
  logic [63:0] p_q;
  logic [5:0]  cnt_q;
  logic        neg_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] sum;
  logic [63:0] p_neg;

  // 0x80000000 negates to itself, which is exactly its magnitude read as unsigned.
  always_comb begin
    a_mag = (bus.is_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    b_mag = (bus.is_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
  end

  always_comb begin
    sum   = {1'b0, p_q[63:32]} + (mult_q[0] ? {1'b0, mcand_q} : 33'd0);
    p_neg = ~p_q + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= 32'd0;
      mult_q  <= 32'd0;
      p_q     <= 64'd0;
      cnt_q   <= 6'd0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mcand_q <= a_mag;
            mult_q  <= b_mag;
            neg_q   <= bus.is_signed & (bus.a[31] ^ bus.b[31]);
            p_q     <= 64'd0;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Shift {carry, P, multiplier} right; the product settles entirely in P.
          p_q    <= {sum, p_q[31:1]};
          mult_q <= {p_q[0], mult_q[31:1]};
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          {hi_q, lo_q} <= neg_q ? p_neg : p_q;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Randomised and directed checks of mult32_seq against a plain-arithmetic product model.
module tb_mult32_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mult32_seq_if bus ();

  mult32_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Wait for DONE, counting edges after the accepting edge; expire after 40.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.done) check("busy_run", 64'(bus.busy), 64'd1);
    end while (!bus.done && n < 40);
  endtask

  // One operation: start pulse, scrambled pins in flight, optional ignored START poke.
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    logic [63:0] exp;
    int n;
    exp = ref_mul(sgn, a, b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.a         = a;
    bus.b         = b;
    @(posedge clk);
    #1;
    check("busy_e0", 64'(bus.busy), 64'd1);
    check("done_e0", 64'(bus.done), 64'd0);
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.is_signed = ~sgn;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (poke && n == 5) begin
        bus.start = 1'b1;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
      end
      if (poke && n == 6) bus.start = 1'b0;
      if (!bus.done) check("busy_run", 64'(bus.busy), 64'd1);
    end while (!bus.done && n < 40);
    check("latency", 64'(n), 64'd33);
    check("busy_fix", 64'(bus.busy), 64'd0);
    check("product", {bus.hi, bus.lo}, exp);
    for (int i = 0; i < (poke ? 40 : 1); i++) begin
      @(posedge clk);
      #1;
      check("done_pulse", 64'(bus.done), 64'd0);
      check("hold", {bus.hi, bus.lo}, exp);
    end
  endtask

  initial begin
    int n;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    #1;
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases, including the boundary operands.
    do_op(1'b1, 32'hFFFF_FFF9, 32'd6, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'd1, 1'b0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b1, 32'd0, 32'h8000_0000, 1'b0);
    do_op(1'b0, 32'd7, 32'd9, 1'b1);

    // Back-to-back with START held high across DONE.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b1;
    bus.a         = 32'd2;
    bus.b         = 32'd3;
    @(posedge clk);
    #1;
    bus.a = 32'd5;
    bus.b = 32'hFFFF_FFFF;
    wait_done(n);
    check("b2b_lat1", 64'(n), 64'd33);
    check("b2b_res1", {bus.hi, bus.lo}, 64'd6);
    @(posedge clk);
    #1;
    check("b2b_acc2", 64'(bus.busy), 64'd1);
    check("b2b_done_low", 64'(bus.done), 64'd0);
    bus.start = 1'b0;
    wait_done(n);
    check("b2b_lat2", 64'(n), 64'd33);
    check("b2b_res2", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFB);

    // Randomised operations with some boundary operands mixed in.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      do_op(1'($urandom_range(0, 1)), ra, rb, 1'b0);
    end

    // Asynchronous reset mid-run abandons the operation.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.a         = 32'h1234_5678;
    bus.b         = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      check("abandon_done", 64'(bus.done), 64'd0);
      check("abandon_busy", 64'(bus.busy), 64'd0);
    end
    do_op(1'b1, 32'hFFFF_FFF9, 32'd6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
